// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard/control unit. Builds the stage stall vector
//               and sequences EX branch/jump redirects, deferring the PC load
//               while an instruction fetch is outstanding.
//               Optional performance counters: define PIPE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_stall_req_i,
    input  logic              id_stall_req_i,
    input  logic              ex_stall_req_i,
    input  logic              mem_stall_req_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              pc_redirect_valid_o,
    output logic [ADDR_W-1:0] pc_redirect_o,
    output logic              busy_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cycles_o,
    output logic [CNT_W-1:0]  perf_flush_cnt_o
`endif
);

    localparam logic [0:0] c_idle    = 1'b0;
    localparam logic [0:0] c_wait_if = 1'b1;

    if (ADDR_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_ctrl: ADDR_W and CNT_W must be at least 1");
    end

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [5:0]        w_stall;
    logic              w_accept;
    logic              w_flush;
    logic              w_pc_valid;
    logic [ADDR_W-1:0] w_pc;

    // Deepest request wins; every vector is a contiguous run of ones from bit 0.
    always_comb begin
        w_stall = 6'b000000;
        if (mem_stall_req_i) begin
            w_stall = 6'b011111;
        end else if (ex_stall_req_i) begin
            w_stall = 6'b001111;
        end else if (id_stall_req_i) begin
            w_stall = 6'b000111;
        end else if (if_stall_req_i || (state_q == c_wait_if)) begin
            w_stall = 6'b000011;
        end
    end

    assign w_accept = redirect_valid_i && !w_stall[3] && (state_q == c_idle);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        w_flush    = 1'b0;
        w_pc_valid = 1'b0;
        w_pc       = '0;
        case (state_q)
            c_idle: begin
                if (w_accept) begin
                    w_flush = 1'b1;
                    if (!if_stall_req_i) begin
                        w_pc_valid = 1'b1;
                        w_pc       = redirect_pc_i;
                    end else begin
                        target_d = redirect_pc_i;
                        state_d  = c_wait_if;
                    end
                end
            end
            c_wait_if: begin
                // EX was flushed on entry, so any redirect seen here is stale.
                w_flush = 1'b1;
                if (!if_stall_req_i) begin
                    w_pc_valid = 1'b1;
                    w_pc       = target_q;
                    state_d    = c_idle;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_idle;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign stall_o             = w_stall;
    assign flush_o             = w_flush;
    assign pc_redirect_valid_o = w_pc_valid;
    assign pc_redirect_o       = w_pc;
    assign busy_o              = (state_q == c_wait_if);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, w_stall[0]};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, w_pc_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cycles_o = stall_cnt_q;
    assign perf_flush_cnt_o    = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard-driven bench for pipe_ctrl (optional counters are
//               exercised when PIPE_PERF_CNT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_stall_req_i = 1'b0;
    logic              id_stall_req_i = 1'b0;
    logic              ex_stall_req_i = 1'b0;
    logic              mem_stall_req_i = 1'b0;
    logic              redirect_valid_i = 1'b0;
    logic [ADDR_W-1:0] redirect_pc_i = '0;
    logic [5:0]        stall_o;
    logic              flush_o;
    logic              pc_redirect_valid_o;
    logic [ADDR_W-1:0] pc_redirect_o;
    logic              busy_o;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  perf_stall_cycles_o;
    logic [CNT_W-1:0]  perf_flush_cnt_o;
`endif

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_stall_req_i      (if_stall_req_i),
        .id_stall_req_i      (id_stall_req_i),
        .ex_stall_req_i      (ex_stall_req_i),
        .mem_stall_req_i     (mem_stall_req_i),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_pc_i       (redirect_pc_i),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .pc_redirect_valid_o (pc_redirect_valid_o),
        .pc_redirect_o       (pc_redirect_o),
        .busy_o              (busy_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cycles_o (perf_stall_cycles_o),
        .perf_flush_cnt_o    (perf_flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard entry layout: {stall[5:0], flush, pc_valid, pc[63:0], busy}
    logic [72:0] exp_q[$];
    logic [72:0] obs_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;

    localparam logic [63:0] PC_A = 64'h0000_0000_8000_0040;
    localparam logic [63:0] PC_W = 64'h0000_0000_8000_0100;
    localparam logic [63:0] PC_E = 64'h0000_0000_8000_0200;
    localparam logic [63:0] PC_M = 64'h0000_0000_8000_0300;
    localparam logic [63:0] PC_B = 64'h0000_0000_8000_0400;
    localparam logic [63:0] PC_X = 64'h0000_0000_DEAD_BEEC;

    // Drive one cycle of stimulus, queue its expectation, capture DUT output at negedge.
    task automatic cyc(input string nm, input logic m, input logic e, input logic d,
                       input logic f, input logic rv, input logic [63:0] rpc,
                       input logic [5:0] e_st, input logic e_fl, input logic e_pv,
                       input logic [63:0] e_pc, input logic e_bz);
        mem_stall_req_i  = m;
        ex_stall_req_i   = e;
        id_stall_req_i   = d;
        if_stall_req_i   = f;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        exp_q.push_back({e_st, e_fl, e_pv, e_pc, e_bz});
        name_q.push_back(nm);
        @(negedge clk);
        obs_q.push_back({stall_o, flush_o, pc_redirect_valid_o, pc_redirect_o, busy_o});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [72:0] e, o;
        string nm;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst_idle", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        cyc("rst_comb_id", 0, 0, 1, 0, 0, '0, 6'b000111, 0, 0, '0, 0);
        rst_n = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_id_stall();
        logic [72:0] e, o;
        string nm;
        cyc("id_stall_c0", 0, 0, 1, 0, 0, '0, 6'b000111, 0, 0, '0, 0);
        cyc("id_stall_c1", 0, 0, 1, 0, 0, '0, 6'b000111, 0, 0, '0, 0);
        cyc("id_stall_off", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [72:0] e, o;
        string nm;
        cyc("prio_mem_id", 1, 0, 1, 0, 0, '0, 6'b011111, 0, 0, '0, 0);
        cyc("prio_ex_if", 0, 1, 0, 1, 0, '0, 6'b001111, 0, 0, '0, 0);
        cyc("prio_if", 0, 0, 0, 1, 0, '0, 6'b000011, 0, 0, '0, 0);
        cyc("prio_mem_blocks_redir", 1, 0, 0, 0, 1, PC_X, 6'b011111, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_redirect_idle();
        logic [72:0] e, o;
        string nm;
        cyc("redir_idle", 0, 0, 0, 0, 1, PC_A, 6'b000000, 1, 1, PC_A, 0);
        cyc("redir_idle_after", 0, 0, 0, 0, 0, PC_A, 6'b000000, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_wait_if();
        logic [72:0] e, o;
        string nm;
        cyc("wif_accept", 0, 0, 0, 1, 1, PC_W, 6'b000011, 1, 0, '0, 0);
        cyc("wif_ignore_redir", 0, 0, 0, 1, 1, PC_X, 6'b000011, 1, 0, '0, 1);
        cyc("wif_mem_prio", 1, 0, 0, 1, 0, '0, 6'b011111, 1, 0, '0, 1);
        cyc("wif_release", 0, 0, 0, 0, 1, PC_X, 6'b000011, 1, 1, PC_W, 1);
        cyc("wif_back_idle", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_ex_hold();
        logic [72:0] e, o;
        string nm;
        cyc("ex_hold_c0", 0, 1, 0, 0, 1, PC_E, 6'b001111, 0, 0, '0, 0);
        cyc("ex_hold_c1", 0, 1, 0, 0, 1, PC_E, 6'b001111, 0, 0, '0, 0);
        cyc("ex_hold_accept", 0, 0, 0, 0, 1, PC_E, 6'b000000, 1, 1, PC_E, 0);
        cyc("ex_hold_idle", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [72:0] e, o;
        string nm;
        cyc("b2b_first", 0, 0, 0, 0, 1, PC_A, 6'b000000, 1, 1, PC_A, 0);
        cyc("b2b_second_id", 0, 0, 1, 0, 1, PC_B, 6'b000111, 1, 1, PC_B, 0);
        cyc("b2b_idle", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [72:0] e, o;
        string nm;
        cyc("mw_enter", 0, 0, 0, 1, 1, PC_M, 6'b000011, 1, 0, '0, 0);
        cyc("mw_wait", 0, 0, 0, 1, 0, '0, 6'b000011, 1, 0, '0, 1);
        // Asynchronous assertion between edges, with IF still stalled.
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, flush_o, pc_redirect_valid_o, stall_o} !== {1'b0, 1'b0, 1'b0, 6'b000011}) begin
            errors++;
            $display("FAIL mw_async_rst: got busy=%b flush=%b pcv=%b stall=%b want 0 0 0 000011",
                     busy_o, flush_o, pc_redirect_valid_o, stall_o);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if ({perf_stall_cycles_o, perf_flush_cnt_o} !== '0) begin
            errors++;
            $display("FAIL mw_perf_clear: got stall_cycles=%0d flush_cnt=%0d want 0 0",
                     perf_stall_cycles_o, perf_flush_cnt_o);
        end
`endif
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("mw_after_rel", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        cyc("mw_after_rel2", 0, 0, 0, 0, 0, '0, 6'b000000, 0, 0, '0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got {stall,flush,pcv,pc,busy}=%h want %h", nm, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_id_stall();
        test_priority();
        test_redirect_idle();
        test_wait_if();
        test_ex_hold();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
